// File: rtl/cache_refill_ctrl.sv
`timescale 1ns/1ps
// cache_refill_ctrl: line-refill sequencer for the cache data and tag RAMs.
// After reset it sweeps every tag entry to invalid, then serves one miss at a
// time: invalidate the set, issue a wrapping burst read, write the returned beats
// critical word first, and finally write {valid,tag} back to the tag RAM.
module cache_refill_ctrl #(
    parameter int TAG_WIDTH  = 20,
    parameter int SET_WIDTH  = 7,
    parameter int WORD_WIDTH = 3
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    output logic                            o_init_done,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    input  logic [TAG_WIDTH-1:0]            i_req_tag,
    input  logic [SET_WIDTH-1:0]            i_req_set,
    input  logic [WORD_WIDTH-1:0]           i_req_word,
    output logic                            o_mem_arvalid,
    input  logic                            i_mem_arready,
    output logic [31:0]                     o_mem_araddr,
    input  logic                            i_mem_rvalid,
    input  logic [31:0]                     i_mem_rdata,
    output logic                            o_mem_rready,
    output logic                            o_dram_wen,
    output logic [SET_WIDTH+WORD_WIDTH-1:0] o_dram_waddr,
    output logic [3:0]                      o_dram_wbyteen,
    output logic [31:0]                     o_dram_wdata,
    output logic                            o_tram_wen,
    output logic [SET_WIDTH-1:0]            o_tram_waddr,
    output logic [TAG_WIDTH:0]              o_tram_wtag,
    output logic                            o_crit_valid,
    output logic [31:0]                     o_crit_data,
    output logic                            o_done
);

    generate
        if (TAG_WIDTH + SET_WIDTH + WORD_WIDTH + 2 != 32) begin : g_bad_cfg
            $fatal(1, "cache_refill_ctrl: address fields must total 32 bits");
        end
    endgenerate

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_TAG  = 3'd4;

    localparam logic [SET_WIDTH-1:0]  SET_ONE   = 1;
    localparam logic [SET_WIDTH-1:0]  SET_LAST  = '1;
    localparam logic [WORD_WIDTH-1:0] WORD_ONE  = 1;
    localparam logic [WORD_WIDTH-1:0] WORD_LAST = '1;

    logic [2:0]            state;
    logic [SET_WIDTH-1:0]  sweep_cnt;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [SET_WIDTH-1:0]  set_q;
    logic [WORD_WIDTH-1:0] ptr_q;
    logic [WORD_WIDTH-1:0] beat_cnt;
    logic [31:0]           araddr_q;

    logic                            vld_p1;
    logic [SET_WIDTH+WORD_WIDTH-1:0] waddr_p1;
    logic [31:0]                     wdata_p1;
    logic                            crit_vld_p1;
    logic [31:0]                     crit_data_p1;

    logic beat_fire;
    logic first_beat;

    // Handshake outputs are decoded from state only, never from inputs.
    assign o_req_ready   = (state == S_IDLE);
    assign o_mem_arvalid = (state == S_ADDR);
    assign o_mem_rready  = (state == S_FILL);
    assign o_mem_araddr  = araddr_q;

    assign beat_fire  = (state == S_FILL) && i_mem_rvalid;
    assign first_beat = beat_fire && (beat_cnt == '0);

    // Control FSM: invalidation sweep, request capture, burst tracking, tag writes.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= S_INIT;
            sweep_cnt    <= '0;
            tag_q        <= '0;
            set_q        <= '0;
            ptr_q        <= '0;
            beat_cnt     <= '0;
            araddr_q     <= '0;
            o_tram_wen   <= 1'b0;
            o_tram_waddr <= '0;
            o_tram_wtag  <= '0;
            o_done       <= 1'b0;
            o_init_done  <= 1'b0;
        end else begin
            o_tram_wen <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                S_INIT: begin
                    o_tram_wen   <= 1'b1;
                    o_tram_waddr <= sweep_cnt;
                    o_tram_wtag  <= '0;
                    sweep_cnt    <= sweep_cnt + SET_ONE;
                    if (sweep_cnt == SET_LAST) begin
                        state       <= S_IDLE;
                        o_init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_req_valid) begin
                        tag_q        <= i_req_tag;
                        set_q        <= i_req_set;
                        ptr_q        <= i_req_word;
                        beat_cnt     <= '0;
                        araddr_q     <= {i_req_tag, i_req_set, i_req_word, 2'b00};
                        // Line is marked invalid for the whole fill.
                        o_tram_wen   <= 1'b1;
                        o_tram_waddr <= i_req_set;
                        o_tram_wtag  <= {1'b0, i_req_tag};
                        state        <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (i_mem_arready) begin
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (i_mem_rvalid) begin
                        ptr_q    <= ptr_q + WORD_ONE;
                        beat_cnt <= beat_cnt + WORD_ONE;
                        if (beat_cnt == WORD_LAST) begin
                            // Tag write and done land together with the last data write.
                            o_tram_wen   <= 1'b1;
                            o_tram_waddr <= set_q;
                            o_tram_wtag  <= {1'b1, tag_q};
                            o_done       <= 1'b1;
                            state        <= S_TAG;
                        end
                    end
                end
                S_TAG: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    // ---- stage p1: registered data RAM write and critical-word pulse ----
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vld_p1       <= 1'b0;
            waddr_p1     <= '0;
            wdata_p1     <= '0;
            crit_vld_p1  <= 1'b0;
            crit_data_p1 <= '0;
        end else begin
            vld_p1      <= beat_fire;
            crit_vld_p1 <= first_beat;
            if (beat_fire) begin
                waddr_p1 <= {set_q, ptr_q};
                wdata_p1 <= i_mem_rdata;
            end
            if (first_beat) begin
                crit_data_p1 <= i_mem_rdata;
            end
        end
    end

    assign o_dram_wen     = vld_p1;
    assign o_dram_waddr   = waddr_p1;
    assign o_dram_wdata   = wdata_p1;
    assign o_dram_wbyteen = {4{vld_p1}};
    assign o_crit_valid   = crit_vld_p1;
    assign o_crit_data    = crit_data_p1;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for cache_refill_ctrl: expected RAM writes, critical words
// and done pulses are queued as stimulus is driven and retired by a monitor.
module tb_cache_refill_ctrl;

    localparam int TW = 20;
    localparam int SW = 7;
    localparam int WW = 3;

    logic              i_clk;
    logic              i_rstn;
    logic              o_init_done;
    logic              i_req_valid;
    logic              o_req_ready;
    logic [TW-1:0]     i_req_tag;
    logic [SW-1:0]     i_req_set;
    logic [WW-1:0]     i_req_word;
    logic              o_mem_arvalid;
    logic              i_mem_arready;
    logic [31:0]       o_mem_araddr;
    logic              i_mem_rvalid;
    logic [31:0]       i_mem_rdata;
    logic              o_mem_rready;
    logic              o_dram_wen;
    logic [SW+WW-1:0]  o_dram_waddr;
    logic [3:0]        o_dram_wbyteen;
    logic [31:0]       o_dram_wdata;
    logic              o_tram_wen;
    logic [SW-1:0]     o_tram_waddr;
    logic [TW:0]       o_tram_wtag;
    logic              o_crit_valid;
    logic [31:0]       o_crit_data;
    logic              o_done;

    cache_refill_ctrl #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .WORD_WIDTH(WW)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .o_init_done(o_init_done),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_tag(i_req_tag), .i_req_set(i_req_set), .i_req_word(i_req_word),
        .o_mem_arvalid(o_mem_arvalid), .i_mem_arready(i_mem_arready),
        .o_mem_araddr(o_mem_araddr), .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata), .o_mem_rready(o_mem_rready),
        .o_dram_wen(o_dram_wen), .o_dram_waddr(o_dram_waddr),
        .o_dram_wbyteen(o_dram_wbyteen), .o_dram_wdata(o_dram_wdata),
        .o_tram_wen(o_tram_wen), .o_tram_waddr(o_tram_waddr),
        .o_tram_wtag(o_tram_wtag), .o_crit_valid(o_crit_valid),
        .o_crit_data(o_crit_data), .o_done(o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [SW+WW+31:0] dq[$];
    logic [SW+TW:0]    tq[$];
    logic [31:0]       cq[$];
    bit                dnq[$];

    int nvec = 0;
    int nmis = 0;

    logic [TW-1:0] nt;
    logic [SW-1:0] ns;
    logic [WW-1:0] nw;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    logic [SW+WW+31:0] exp_d;
    logic [SW+TW:0]    exp_t;
    logic [31:0]       exp_c;
    bit                exp_dn;

    // Retire expected writes/pulses as the DUT produces them.
    always @(negedge i_clk) begin
        if (o_dram_wen) begin
            if (dq.size() == 0) chk("dram_extra", 64'd1, 64'd0);
            else begin
                exp_d = dq.pop_front();
                chk("dram_wr", {o_dram_waddr, o_dram_wdata}, exp_d);
                chk("dram_be", o_dram_wbyteen, 4'hF);
            end
        end
        if (o_tram_wen) begin
            if (tq.size() == 0) chk("tram_extra", {o_tram_waddr, o_tram_wtag}, 64'd0);
            else begin
                exp_t = tq.pop_front();
                chk("tram_wr", {o_tram_waddr, o_tram_wtag}, exp_t);
            end
        end
        if (o_crit_valid) begin
            if (cq.size() == 0) chk("crit_extra", 64'd1, 64'd0);
            else begin
                exp_c = cq.pop_front();
                chk("crit_data", o_crit_data, exp_c);
            end
        end
        if (o_done) begin
            if (dnq.size() == 0) chk("done_extra", 64'd1, 64'd0);
            else begin
                exp_dn = dnq.pop_front();
                chk("done_tagwr", {o_tram_wen, o_tram_wtag[TW]}, {exp_dn, 1'b1});
            end
        end
    end

    task automatic reset_sweep();
        int  n;
        bit  early;
        logic [SW-1:0] sa;
        i_rstn = 1'b0;
        #1;
        chk("rst_outs", {o_dram_wen, o_tram_wen, o_crit_valid, o_done, o_init_done,
                         o_mem_arvalid, o_mem_rready, o_req_ready}, 64'd0);
        chk("rst_araddr", o_mem_araddr, 64'd0);
        dq.delete(); tq.delete(); cq.delete(); dnq.delete();
        for (int s = 0; s < (1 << SW); s++) begin
            sa = s[SW-1:0];
            tq.push_back({sa, {(TW+1){1'b0}}});
        end
        @(negedge i_clk);
        i_rstn = 1'b1;
        early = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge i_clk); #1;
            n++;
            if (o_init_done) break;
            if (o_req_ready) early = 1'b1;
        end
        chk("init_cycles", n, 128);
        chk("rdy_in_init", early, 0);
    endtask

    task automatic refill(input logic [TW-1:0] tg, input logic [SW-1:0] st,
                          input logic [WW-1:0] wd, input int ar_dly, input int gmax,
                          input int stop_after, input bit hold, input logic [31:0] dbase);
        logic [31:0]   exp_addr;
        logic [31:0]   dv;
        logic [WW-1:0] p;
        int            n;
        i_req_tag   = tg;
        i_req_set   = st;
        i_req_word  = wd;
        i_req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_req_ready && n < 300);
        chk("req_ready", o_req_ready, 1);
        if (!o_req_ready) return;
        tq.push_back({st, 1'b0, tg});
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        exp_addr = {tg, st, wd, 2'b00};
        chk("arvalid", o_mem_arvalid, 1);
        chk("araddr", o_mem_araddr, exp_addr);
        repeat (ar_dly) begin
            @(posedge i_clk); #1;
            chk("ar_hold", {o_mem_arvalid, o_mem_araddr}, {1'b1, exp_addr});
        end
        i_mem_arready = 1'b1;
        @(posedge i_clk); #1;
        i_mem_arready = 1'b0;
        chk("fill_hs", {o_mem_rready, o_mem_arvalid}, 2'b10);
        if (hold) begin
            i_req_tag = nt; i_req_set = ns; i_req_word = nw; i_req_valid = 1'b1;
        end
        p = wd;
        for (int b = 0; b < stop_after; b++) begin
            repeat ($urandom_range(gmax, 0)) begin
                @(posedge i_clk); #1;
            end
            dv = dbase + 32'(b);
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = dv;
            dq.push_back({st, p, dv});
            if (b == 0) cq.push_back(dv);
            if (b == (1 << WW) - 1) begin
                tq.push_back({st, 1'b1, tg});
                dnq.push_back(1'b1);
            end
            @(posedge i_clk); #1;
            i_mem_rvalid = 1'b0;
            p = p + WW'(1);
            if (b == 0) chk("crit_pulse", o_crit_valid, 1);
            if (hold) chk("rdy_in_fill", o_req_ready, 0);
        end
        if (stop_after == (1 << WW)) chk("done_lat", o_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rstn = 1'b0; i_req_valid = 1'b0; i_req_tag = '0; i_req_set = '0; i_req_word = '0;
        i_mem_arready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        nt = '0; ns = '0; nw = '0;
        #12;
        // Request already pending while the sweep runs.
        i_req_tag = 20'hABCDE; i_req_set = 7'd5; i_req_word = 3'd0; i_req_valid = 1'b1;
        reset_sweep();
        refill(20'hABCDE, 7'd5, 3'd0, 0, 0, 8, 1'b0, 32'hD000_0000);
        // Critical word 6 (wraps 7->0), next request held through the fill.
        nt = 20'h2468A; ns = 7'd64; nw = 3'd7;
        refill(20'h13579, 7'd33, 3'd6, 0, 1, 8, 1'b1, 32'hC0DE_0010);
        refill(nt, ns, nw, 1, 0, 8, 1'b0, 32'h5555_AA00);
        // Slow address accept and gappy data, max set index.
        refill(20'hFFFFF, 7'd127, 3'd3, 4, 3, 8, 1'b0, 32'h1234_5670);
        // Reset after the fourth beat abandons the refill.
        refill(20'h12345, 7'd9, 3'd2, 0, 0, 4, 1'b0, 32'hBEEF_0000);
        #2;
        reset_sweep();
        refill(20'h0F0F0, 7'd0, 3'd7, 1, 2, 8, 1'b0, 32'h7777_0000);
        repeat (4) @(posedge i_clk);
        #1;
        chk("dq_left", dq.size(), 0);
        chk("tq_left", tq.size(), 0);
        chk("cq_left", cq.size(), 0);
        chk("dnq_left", dnq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
